// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential 8-digit packed BCD to binary converter, one digit per clock, MSD first.
// Define BCD2BIN_ERRCHK_EN to flag digits greater than 9 on err; otherwise err is tied low.
module bcd2bin_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] bcd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] bin_out,
  output logic        err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [31:0] sr_q, sr_d, acc_q, acc_d, bin_q, bin_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  digit;
  logic [31:0] acc_nx;
  logic        accept, last;
  assign accept = (state_q == IDLE) && start;
  assign last   = (state_q == CONV) && (idx_q == 3'd0);
  assign digit  = sr_q[31:28];
  assign acc_nx = (acc_q << 3) + (acc_q << 1) + {28'd0, digit};
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    bin_d   = last ? acc_nx : bin_q;
    if (accept) begin
      sr_d    = bcd_in;
      acc_d   = 32'd0;
      idx_d   = 3'd7;
      state_d = CONV;
    end else if (state_q == CONV) begin
      sr_d    = sr_q << 4;
      acc_d   = acc_nx;
      idx_d   = idx_q - 3'd1;
      state_d = last ? DONE : CONV;
    end else if (state_q != IDLE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= 32'd0;
      acc_q   <= 32'd0;
      idx_q   <= 3'd0;
      bin_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      bin_q   <= bin_d;
    end
  end
  assign busy    = (state_q == CONV);
  assign done    = (state_q == DONE);
  assign bin_out = bin_q;
`ifdef BCD2BIN_ERRCHK_EN
  // Sticky over the whole conversion, published only at completion.
  logic flag_q, flag_d, err_q, err_d;
  always_comb begin
    flag_d = accept ? 1'b0 : (state_q == CONV) ? (flag_q | (digit > 4'd9)) : flag_q;
    err_d  = last ? flag_d : err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 The block SHALL have the following ports, clock and reset first.
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_in  input  32  eight packed BCD digits; digit 7 in [31:28], digit 0 in [3:0].
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse marking bin_out and err valid.
- bin_out  output  32  unsigned binary result, zero-extended, held until the next completion.
- err  output  1  invalid-digit flag, valid with done.

REQ-002 The block SHALL have no parameters; the digit count is fixed at 8.

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, CONV, DONE.
REQ-004 In IDLE with start=1 at rising edge E0, the block SHALL latch bcd_in into an internal shift register, clear the accumulator, set the digit index to 7 and enter CONV.
REQ-005 Changes to bcd_in after E0 SHALL NOT affect the current conversion.
REQ-006 In CONV, one digit per edge, most significant first (edges E1..E8), the block SHALL compute acc = acc*10 + digit, with acc*10 formed as (acc<<3)+(acc<<1) in 32-bit arithmetic.
REQ-007 At E8, after digit 0 is processed, the block SHALL load bin_out with acc and enter DONE.
REQ-008 busy SHALL be 1 exactly while the state is CONV (8 cycles per conversion).
REQ-009 done SHALL be 1 exactly while the state is DONE (a single cycle); DONE SHALL go to IDLE unconditionally on the next edge.
REQ-010 Latency from start sampled to done high SHALL be 8 clock cycles; minimum start-to-start spacing SHALL be 10 cycles.
REQ-011 start SHALL be ignored in CONV and DONE; it is not queued.
REQ-012 bin_out SHALL change only at the CONV-to-DONE transition.
REQ-013 The maximum legal input 0x99999999 SHALL produce 99,999,999 (27 bits); bin_out[31:27] SHALL be 0 for legal inputs.
REQ-014 A digit greater than 9 SHALL still be accumulated using its raw 4-bit value; no saturation and no abort.

Reset
REQ-015 rst_n low SHALL asynchronously force state=IDLE, busy=0, done=0, bin_out=0, err=0, and clear the accumulator, shift register and index.
REQ-016 Reset asserted mid-CONV SHALL abandon the conversion; done SHALL NOT pulse for it.
REQ-017 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled.

Configuration
REQ-018 The block SHALL have one compile-time option, macro BCD2BIN_ERRCHK_EN.
REQ-019 With BCD2BIN_ERRCHK_EN defined, the block SHALL:
- set a sticky internal flag when any processed digit is greater than 9;
- clear that flag when start is accepted;
- copy the flag to err at the CONV-to-DONE transition;
- hold err until the next completion or reset.
REQ-020 With BCD2BIN_ERRCHK_EN undefined, err SHALL be tied to 0 and no digit-check logic SHALL be synthesised; all other behaviour SHALL be identical.

Verification
REQ-021 A bench SHALL cover each of the following directed scenarios:
- bcd_in=0x12345678, start pulse -> busy for 8 cycles; done 8 cycles after start with bin_out=0x00BC614E, err=0.
- bcd_in=0x99999999 -> bin_out=0x05F5E0FF.
- bcd_in=0x00000000 -> bin_out=0x00000000.
- bcd_in=0x00000021 then 0x00000007 (10 cycles apart) -> bin_out=0x15, then 0x7.
- start re-pulsed at cycle 3 of CONV with bcd_in=0x00000005 -> ignored; single done with bin_out=0x00BC614E.
- rst_n pulsed low during cycle 4 of CONV -> all outputs 0 immediately; no done; next start with 0x00000042 -> bin_out=0x2A.
- bcd_in=0x0000000A -> bin_out=0x0000000A; err=1 with BCD2BIN_ERRCHK_EN defined, err=0 without; a following 0x00000009 conversion -> err=0.
